dpi_stream_sequencer: RTL and testbench
=======================================

Name: dpi_stream_sequencer

Overview:
- Upstream feeder for the per-regex matcher bank in the packet-inspection core.
- Accepts a byte stream framed by sop/eop with a 32-bit flow key, and maps the key to a 6-bit stream id through a 64-entry flow table.
- Issues load_state/new_stream_id, then the character stream, then a delayed eop, all timed to the matchers' registered-input pipeline.
- Broadcasts the regex enable mask to all matchers.

Parameters:
- NUM_REGEX, 8, number of matchers fed; width of enable output.
- LOAD_GAP, 3, cycles from load_state pulse to first char_in_vld (min 2).
- EOP_GAP, 4, cycles from last char_in_vld to eop pulse (min 1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_data  in  8  packet byte.
- in_vld  in  1  in_data/in_sop/in_eop/in_key valid.
- in_sop  in  1  first byte of packet; in_key valid with it.
- in_eop  in  1  last byte of packet.
- in_key  in  32  flow key (sampled on the sop beat).
- in_ready  out  1  beat consumed when in_vld & in_ready.
- cfg_enable  in  NUM_REGEX  per-matcher enable mask.
- cfg_flush  in  1  invalidate all flow table entries.
- char_in  out  8  byte to matchers.
- char_in_vld  out  1  char_in valid.
- load_state  out  1  one-cycle pulse, start of packet.
- stream_id  out  6  stream id, stable from load_state through eop.
- new_stream_id  out  1  with load_state: flow newly allocated.
- eop  out  1  one-cycle pulse, end of packet.
- enable  out  NUM_REGEX  registered cfg_enable.
- busy  out  1  FSM not in IDLE.
- pkt_cnt  out  16  packets sequenced, wraps at 65535->0.
- drop_cnt  out  16  non-sop beats discarded in IDLE, saturates at 65535.

Behaviour:
- Reset (async):
  - FSM to IDLE; table valid bits, alloc_ptr and all outputs cleared.
  - Reset mid-packet abandons the packet; no eop is issued.
- All outputs are registered; enable = cfg_enable delayed one cycle.
- IDLE:
  - in_ready=1 only if !(in_vld & in_sop).
  - A non-sop beat is consumed and dropped; drop_cnt increments.
  - On in_vld & in_sop: latch in_key, leave the beat unconsumed, go to LOOKUP.
  - cfg_flush is honoured only in IDLE: clears all valid bits and alloc_ptr in one cycle. If flush and sop occur in the same cycle, the flush wins and the sop is processed next cycle.
- LOOKUP (1 cycle): parallel compare of the latched key against the 64 valid entries.
  - Hit: stream_id = index of the hit, new_stream_id = 0.
  - Miss: stream_id = alloc_ptr; write the key and set valid; alloc_ptr increments mod 64. When the table is full, the oldest allocation is overwritten (FIFO replacement). new_stream_id = 1.
  - Next state LOAD.
- LOAD (1 cycle): load_state = 1, new_stream_id as resolved. Next state GAP.
- GAP: wait LOAD_GAP-1 cycles, then STREAM. The first char_in_vld therefore occurs exactly LOAD_GAP cycles after load_state.
- STREAM:
  - in_ready = 1; each accepted beat produces char_in = in_data, char_in_vld = 1 on the next cycle.
  - Bubbles (in_vld = 0) give char_in_vld = 0.
  - in_sop seen in STREAM is ignored (treated as data).
  - Accepting a beat with in_eop moves to DRAIN; in_ready drops the same cycle.
- DRAIN: wait so that eop pulses exactly EOP_GAP cycles after the last char_in_vld.
- EOP: eop = 1 for one cycle; pkt_cnt increments; go to IDLE. A new sop is first accepted in the cycle after eop.
- Single-beat packet (sop & eop together): one char_in_vld, normal gaps apply.
- stream_id holds its value after eop until the next LOOKUP.
- Minimum per-packet overhead: 1 (LOOKUP) + 1 (LOAD) + LOAD_GAP-1 + EOP_GAP + 1 (EOP) cycles beyond the data beats.

Test Plan:
- Reset, then a 4-byte packet with key 0xA5A5_0001 and no gaps -> load_state at cycle t with stream_id = 0 and new_stream_id = 1; char_in_vld on t+3..t+6 carrying bytes in order; eop at t+10; pkt_cnt = 1.
- Second packet with the same key -> stream_id = 0, new_stream_id = 0. A third packet with key 0x2 -> stream_id = 1, new_stream_id = 1.
- 65 distinct keys, then key #0 again -> key #64 gets stream_id 0 (wrap/overwrite); key #0 misses and allocates stream_id 1 with new_stream_id = 1.
- Packet with in_vld bubbles and the sop+eop single-byte case -> char_in_vld only on accepted beats; eop exactly EOP_GAP after the last char; in_ready = 0 outside STREAM/IDLE.
- Three non-sop beats in IDLE -> all consumed, drop_cnt = 3, no load_state. A sop coincident with cfg_flush -> flush wins, then the key allocates stream_id 0 with new_stream_id = 1.
- Assert rst mid-STREAM -> outputs 0 immediately, busy = 0, no eop; the next packet with a previously seen key is treated as new (stream_id 0, new_stream_id = 1).

Source files
------------

// File: rtl/dpi_stream_sequencer.sv
// Front-end sequencer for the regex matcher bank: maps flow keys to stream ids and
// replays packet bytes with load_state/eop timing aligned to the matchers' pipeline.
module dpi_stream_sequencer #(
  parameter int unsigned NUM_REGEX = 8,
  parameter int unsigned LOAD_GAP  = 3,
  parameter int unsigned EOP_GAP   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_vld,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [31:0]          in_key,
  output logic                 in_ready,
  input  logic [NUM_REGEX-1:0] cfg_enable,
  input  logic                 cfg_flush,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 load_state,
  output logic [5:0]           stream_id,
  output logic                 new_stream_id,
  output logic                 eop,
  output logic [NUM_REGEX-1:0] enable,
  output logic                 busy,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          drop_cnt
);

  typedef enum logic [2:0] {
    StIdle, StLookup, StLoad, StGap, StStream, StDrain, StEop
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [31:0]           key_q, key_d;
  logic [63:0]           valid_q, valid_d;
  logic [5:0]            alloc_q, alloc_d;
  logic [5:0]            sid_q, sid_d;
  logic                  new_q, new_d;
  logic [7:0]            char_q, char_d;
  logic                  char_vld_q, char_vld_d;
  logic [15:0]           pkt_q, pkt_d;
  logic [15:0]           drop_q, drop_d;
  logic [NUM_REGEX-1:0]  enable_q;
  logic [31:0]           key_tbl_q [64];

  logic                  hit;
  logic [5:0]            hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (!hit && valid_q[i] && key_tbl_q[i] == key_q) begin
        hit     = 1'b1;
        hit_idx = 6'(i);
      end
    end
  end

  // Ready is a decode of current state plus the incoming beat: a sop in IDLE must stay
  // pending until the lookup/load preamble has been issued.
  assign in_ready = (state_q == StStream) || ((state_q == StIdle) && !(in_vld && in_sop));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    valid_d    = valid_q;
    alloc_d    = alloc_q;
    sid_d      = sid_q;
    new_d      = new_q;
    char_d     = char_q;
    char_vld_d = 1'b0;
    pkt_d      = pkt_q;
    drop_d     = drop_q;
    case (state_q)
      StIdle: begin
        if (in_vld && !in_sop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        if (cfg_flush) begin
          valid_d = '0;
          alloc_d = '0;
        end else if (in_vld && in_sop) begin
          key_d   = in_key;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          sid_d = hit_idx;
          new_d = 1'b0;
        end else begin
          sid_d            = alloc_q;
          new_d            = 1'b1;
          valid_d[alloc_q] = 1'b1;
          alloc_d          = alloc_q + 6'd1;
        end
        state_d = StLoad;
      end
      StLoad: begin
        new_d = 1'b0;
        if (LOAD_GAP <= 2) begin
          state_d = StStream;
        end else begin
          cnt_d   = 16'(LOAD_GAP - 3);
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == 16'd0) state_d = StStream;
        else                cnt_d   = cnt_q - 16'd1;
      end
      StStream: begin
        if (in_vld) begin
          char_d     = in_data;
          char_vld_d = 1'b1;
          if (in_eop) begin
            cnt_d   = 16'(EOP_GAP - 1);
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (cnt_q == 16'd0) state_d = StEop;
        else                cnt_d   = cnt_q - 16'd1;
      end
      StEop: begin
        pkt_d   = pkt_q + 16'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      key_q      <= '0;
      valid_q    <= '0;
      alloc_q    <= '0;
      sid_q      <= '0;
      new_q      <= 1'b0;
      char_q     <= '0;
      char_vld_q <= 1'b0;
      pkt_q      <= '0;
      drop_q     <= '0;
      enable_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      alloc_q    <= alloc_d;
      sid_q      <= sid_d;
      new_q      <= new_d;
      char_q     <= char_d;
      char_vld_q <= char_vld_d;
      pkt_q      <= pkt_d;
      drop_q     <= drop_d;
      enable_q   <= cfg_enable;
    end
  end

  // Key storage needs no reset; the valid bits gate every compare.
  always_ff @(posedge clk) begin
    if (state_q == StLookup && !hit) key_tbl_q[alloc_q] <= key_q;
  end

  assign char_in       = char_q;
  assign char_in_vld   = char_vld_q;
  assign load_state    = (state_q == StLoad);
  assign stream_id     = sid_q;
  assign new_stream_id = new_q;
  assign eop           = (state_q == StEop);
  assign enable        = enable_q;
  assign busy          = (state_q != StIdle);
  assign pkt_cnt       = pkt_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: packet timing, flow-table allocation,
// wrap/overwrite, drops, flush and mid-packet reset.
module tb_dpi_stream_sequencer;

  logic        clk, rst;
  logic [7:0]  in_data;
  logic        in_vld, in_sop, in_eop;
  logic [31:0] in_key;
  logic        in_ready;
  logic [7:0]  cfg_enable;
  logic        cfg_flush;
  logic [7:0]  char_in;
  logic        char_in_vld, load_state, new_stream_id, eop, busy;
  logic [5:0]  stream_id;
  logic [7:0]  enable;
  logic [15:0] pkt_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;

  dpi_stream_sequencer #(.NUM_REGEX(8), .LOAD_GAP(3), .EOP_GAP(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_sop(in_sop),
    .in_eop(in_eop), .in_key(in_key), .in_ready(in_ready), .cfg_enable(cfg_enable),
    .cfg_flush(cfg_flush), .char_in(char_in), .char_in_vld(char_in_vld),
    .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
    .eop(eop), .enable(enable), .busy(busy), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event recorder, sampled on the falling edge.
  int         cyc = 0;
  int         t_load, t_first, t_last, t_eop;
  int         n_load = 0;
  int         n_eop = 0;
  logic [5:0] ld_sid;
  logic       ld_new;
  logic [7:0] chars[$];

  always @(negedge clk) begin
    cyc++;
    if (load_state) begin
      t_load = cyc; ld_sid = stream_id; ld_new = new_stream_id; n_load++;
      chars.delete();
    end
    if (char_in_vld) begin
      if (chars.size() == 0) t_first = cyc;
      chars.push_back(char_in);
      t_last = cyc;
    end
    if (eop) begin
      t_eop = cyc; n_eop++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic e, input logic [31:0] k);
    logic r;
    int   n;
    in_vld = 1'b1; in_data = d; in_sop = s; in_eop = e; in_key = k;
    n = 0;
    do begin
      #4 r = in_ready;
      @(negedge clk);
      n++;
    end while (!r && n < 100);
    check("beat_accept", {31'd0, r}, 32'd1);
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic bubble();
    in_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_eop(input int start);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (n_eop != start) break;
    end
    @(negedge clk);
    check("eop_seen", n_eop, start + 1);
  endtask

  task automatic one_byte(input logic [31:0] k);
    int s;
    s = n_eop;
    beat(8'h5C, 1'b1, 1'b1, k);
    wait_eop(s);
  endtask

  initial begin
    int s, l;
    rst = 1'b1; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; in_key = '0;
    cfg_enable = 8'h5A; cfg_flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_load", {31'd0, load_state}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cvld", {31'd0, char_in_vld}, 32'd0);
    check("rst_pkt", {16'd0, pkt_cnt}, 32'd0);
    check("rst_enable", {24'd0, enable}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("enable_reg", {24'd0, enable}, 32'h5A);
    check("idle_ready", {31'd0, in_ready}, 32'd1);

    // 4-byte packet, no gaps
    s = n_eop;
    beat(8'h11, 1'b1, 1'b0, 32'hA5A5_0001);
    beat(8'h22, 1'b0, 1'b0, 32'h0);
    beat(8'h33, 1'b0, 1'b0, 32'h0);
    beat(8'h44, 1'b0, 1'b1, 32'h0);
    check("drain_ready", {31'd0, in_ready}, 32'd0);
    wait_eop(s);
    check("p1_sid", {26'd0, ld_sid}, 32'd0);
    check("p1_new", {31'd0, ld_new}, 32'd1);
    check("p1_first", t_first - t_load, 32'd3);
    check("p1_last", t_last - t_load, 32'd6);
    check("p1_eop", t_eop - t_load, 32'd10);
    check("p1_len", chars.size(), 32'd4);
    check("p1_b0", {24'd0, chars[0]}, 32'h11);
    check("p1_b3", {24'd0, chars[3]}, 32'h44);
    check("p1_pkt", {16'd0, pkt_cnt}, 32'd1);
    check("p1_busy", {31'd0, busy}, 32'd0);

    one_byte(32'hA5A5_0001);
    check("p2_sid", {26'd0, ld_sid}, 32'd0);
    check("p2_new", {31'd0, ld_new}, 32'd0);
    one_byte(32'h0000_0002);
    check("p3_sid", {26'd0, ld_sid}, 32'd1);
    check("p3_new", {31'd0, ld_new}, 32'd1);
    check("p3_sid_hold", {26'd0, stream_id}, 32'd1);

    // Flush, then 65 distinct keys: the 65th wraps onto entry 0
    cfg_flush = 1'b1;
    @(negedge clk);
    cfg_flush = 1'b0;
    for (int i = 0; i < 65; i++) begin
      one_byte(32'h1000 + i);
      if (i == 63) check("k63_sid", {26'd0, ld_sid}, 32'd63);
    end
    check("k64_sid", {26'd0, ld_sid}, 32'd0);
    check("k64_new", {31'd0, ld_new}, 32'd1);
    one_byte(32'h1000);
    check("k0_sid", {26'd0, ld_sid}, 32'd1);
    check("k0_new", {31'd0, ld_new}, 32'd1);
    one_byte(32'h1002);
    check("k2_sid", {26'd0, ld_sid}, 32'd2);
    check("k2_new", {31'd0, ld_new}, 32'd0);

    // Bubbles inside a packet
    s = n_eop;
    beat(8'hA1, 1'b1, 1'b0, 32'h3000);
    bubble();
    beat(8'hA2, 1'b0, 1'b0, 32'h0);
    bubble();
    bubble();
    beat(8'hA3, 1'b0, 1'b1, 32'h0);
    check("bub_ready", {31'd0, in_ready}, 32'd0);
    wait_eop(s);
    check("bub_sid", {26'd0, ld_sid}, 32'd2);
    check("bub_len", chars.size(), 32'd3);
    check("bub_b1", {24'd0, chars[1]}, 32'hA2);
    check("bub_first", t_first - t_load, 32'd3);
    check("bub_eopgap", t_eop - t_last, 32'd4);
    check("bub_span", t_last - t_first, 32'd5);

    // Single-beat packet
    one_byte(32'h3000);
    check("sb_new", {31'd0, ld_new}, 32'd0);
    check("sb_len", chars.size(), 32'd1);
    check("sb_eop", t_eop - t_load, 32'd7);

    // Non-sop beats in IDLE are dropped
    l = n_load;
    beat(8'h01, 1'b0, 1'b0, 32'h0);
    beat(8'h02, 1'b0, 1'b1, 32'h0);
    beat(8'h03, 1'b0, 1'b0, 32'h0);
    bubble();
    check("drop_cnt", {16'd0, drop_cnt}, 32'd3);
    check("drop_noload", n_load, l);

    // sop coincident with flush: flush wins, sop is taken next cycle
    in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = 8'h77; in_key = 32'h1002;
    cfg_flush = 1'b1;
    @(negedge clk);
    cfg_flush = 1'b0;
    check("flush_idle", {31'd0, busy}, 32'd0);
    s = n_eop;
    beat(8'h77, 1'b1, 1'b1, 32'h1002);
    wait_eop(s);
    check("fl_sid", {26'd0, ld_sid}, 32'd0);
    check("fl_new", {31'd0, ld_new}, 32'd1);

    // Reset in the middle of a packet
    beat(8'hC1, 1'b1, 1'b0, 32'h55);
    check("mr_sid", {26'd0, ld_sid}, 32'd1);
    beat(8'hC2, 1'b0, 1'b0, 32'h0);
    s = n_eop;
    rst = 1'b1;
    #1;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_cvld", {31'd0, char_in_vld}, 32'd0);
    check("mr_pkt", {16'd0, pkt_cnt}, 32'd0);
    check("mr_drop", {16'd0, drop_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("mr_noeop", n_eop, s);
    one_byte(32'h55);
    check("mr2_sid", {26'd0, ld_sid}, 32'd0);
    check("mr2_new", {31'd0, ld_new}, 32'd1);
    check("mr2_pkt", {16'd0, pkt_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
